// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared ramControl width codes, controller FSM state and request type
// Ports: none (package). Provides RC_* width codes, ram_ctrl_state_t, mem_req_t and
// rc_misaligned(), which flags an address that is illegal for a width code.
package mem_pkg;

  localparam logic [2:0] RC_BYTE  = 3'b001;
  localparam logic [2:0] RC_HALF  = 3'b010;
  localparam logic [2:0] RC_BYTEU = 3'b101;
  localparam logic [2:0] RC_HALFU = 3'b110;
  // Any code not listed above also means word; this is the canonical one.
  localparam logic [2:0] RC_WORD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } ram_ctrl_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } mem_req_t;

  // Bytes are always aligned, halves need addr[0]=0, everything else is a word.
  function automatic logic rc_misaligned(input logic [1:0] a, input logic [2:0] c);
    case (c)
      RC_BYTE, RC_BYTEU: rc_misaligned = 1'b0;
      RC_HALF, RC_HALFU: rc_misaligned = a[0];
      default:           rc_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - one requester's access port into ram_access_ctrl
// Signals: req/we/addr/wdata/ctrl (requester -> controller),
//          done/err/rdata (controller -> requester).
// Modports: master (requester side), slave (controller side).
interface ram_access_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ctrl;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, ctrl, input done, err, rdata);
  modport slave  (input req, we, addr, wdata, ctrl, output done, err, rdata);
endinterface

// File: rtl/ram_rr_arb2.sv
// rtl/ram_rr_arb2.sv - combinational 2-way round-robin pick with fixed-priority fallback
// Ports: req[1:0] requests, last_idx index granted last, rr_en 1=round-robin 0=index 0 wins,
//        gnt_valid any request present, gnt_idx granted index.
module ram_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_idx,
  input  logic       rr_en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;

  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = rr_en ? ~last_idx : 1'b0;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - two-requester arbiter and access sequencer for the data RAM
// Ports: clk, reset_n (async active-low); m0/m1 requester ports (slave modport);
//        ram_we/ram_addr/ram_wdata/ram_ctrl registered RAM drive, ram_rdata combinational
//        RAM read data. One access per IDLE->ACCESS->RESP pass; done pulses in RESP.
module ram_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter bit RR_EN     = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  ram_access_ctrl_if.slave    m0,
  ram_access_ctrl_if.slave    m1,
  output logic                ram_we,
  output logic [31:0]         ram_addr,
  output logic [31:0]         ram_wdata,
  output logic [2:0]          ram_ctrl,
  input  logic [31:0]         ram_rdata
);

  ram_ctrl_state_t state;
  mem_req_t        lat;
  logic            gidx;
  logic            err_q;
  logic            last_q;
  logic [1:0]      done_q;
  logic [1:0]      err_o;
  logic [31:0]     rdata0_q;
  logic [31:0]     rdata1_q;

  logic            gnt_valid;
  logic            gnt_idx;
  mem_req_t        pick;
  logic            pick_err;

  ram_rr_arb2 u_arb (
    .req       ({m1.req, m0.req}),
    .last_idx  (last_q),
    .rr_en     (RR_EN),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    pick.we    = gnt_idx ? m1.we    : m0.we;
    pick.addr  = gnt_idx ? m1.addr  : m0.addr;
    pick.wdata = gnt_idx ? m1.wdata : m0.wdata;
    pick.ctrl  = gnt_idx ? m1.ctrl  : m0.ctrl;
  end

  assign pick_err = rc_misaligned(pick.addr[1:0], pick.ctrl)
                  | (pick.addr[31:2] >= 30'(MEM_WORDS));

  // The latched request doubles as the registered RAM address/data/width drive,
  // so those outputs hold the last granted values between accesses.
  assign ram_addr  = lat.addr;
  assign ram_wdata = lat.wdata;
  assign ram_ctrl  = lat.ctrl;

  assign m0.done  = done_q[0];
  assign m1.done  = done_q[1];
  assign m0.err   = err_o[0];
  assign m1.err   = err_o[1];
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      lat      <= '0;
      gidx     <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;           // m0 wins the first tie
      ram_we   <= 1'b0;
      done_q   <= 2'b00;
      err_o    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            lat    <= pick;
            gidx   <= gnt_idx;
            err_q  <= pick_err;
            ram_we <= pick.we & ~pick_err;
            state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          ram_we <= 1'b0;
          // Stores leave the requester's rdata untouched; rejected loads return 0.
          if (!lat.we) begin
            if (gidx) rdata1_q <= err_q ? 32'h0 : ram_rdata;
            else      rdata0_q <= err_q ? 32'h0 : ram_rdata;
          end
          done_q <= gidx ? 2'b10 : 2'b01;
          err_o  <= gidx ? {err_q, 1'b0} : {1'b0, err_q};
          state  <= ST_RESP;
        end
        ST_RESP: begin
          done_q <= 2'b00;
          err_o  <= 2'b00;
          last_q <= gidx;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ram_access_ctrl_if a_m0 ();
  ram_access_ctrl_if a_m1 ();
  ram_access_ctrl_if b_m0 ();
  ram_access_ctrl_if b_m1 ();

  logic        a_ram_we, b_ram_we;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [2:0]  a_ram_ctrl, b_ram_ctrl;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  ram_access_ctrl #(.MEM_WORDS(256), .RR_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .m0(a_m0), .m1(a_m1),
    .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_ctrl(a_ram_ctrl), .ram_rdata(a_ram_rdata)
  );

  ram_access_ctrl #(.MEM_WORDS(256), .RR_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .m0(b_m0), .m1(b_m1),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_ctrl(b_ram_ctrl), .ram_rdata(b_ram_rdata)
  );

  // Behavioural RAM: synchronous little-endian write, combinational extended read.
  function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [1:0] a,
                                            input logic [31:0] wd, input logic [2:0] c);
    logic [31:0] r;
    r = old;
    case (c)
      3'b001, 3'b101: r[{a, 3'b000} +: 8] = wd[7:0];
      3'b010, 3'b110: r[{a[1], 4'b0000} +: 16] = wd[15:0];
      default:        r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] c);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (c)
      3'b001:  return {{24{b[7]}}, b};
      3'b101:  return {24'h0, b};
      3'b010:  return {{16{h[15]}}, h};
      3'b110:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (a_ram_we) mem_a[a_ram_addr[9:2]] <= ram_merge(mem_a[a_ram_addr[9:2]], a_ram_addr[1:0], a_ram_wdata, a_ram_ctrl);
    if (b_ram_we) mem_b[b_ram_addr[9:2]] <= ram_merge(mem_b[b_ram_addr[9:2]], b_ram_addr[1:0], b_ram_wdata, b_ram_ctrl);
  end

  assign a_ram_rdata = ram_read(mem_a[a_ram_addr[9:2]], a_ram_addr[1:0], a_ram_ctrl);
  assign b_ram_rdata = ram_read(mem_b[b_ram_addr[9:2]], b_ram_addr[1:0], b_ram_ctrl);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int m, input logic r, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] c);
    if (m == 0) begin
      a_m0.req = r; a_m0.we = we; a_m0.addr = addr; a_m0.wdata = wd; a_m0.ctrl = c;
    end else begin
      a_m1.req = r; a_m1.we = we; a_m1.addr = addr; a_m1.wdata = wd; a_m1.ctrl = c;
    end
  endtask

  // Issues one access on DUT A from IDLE and reports latency (ticks to done, -1 on
  // timeout), number of ram_we cycles, and err/rdata seen with done. Ends in IDLE.
  task automatic run_a(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] c,
                       output int lat, output int wec, output logic err, output logic [31:0] rd);
    logic d;
    lat = -1; wec = 0; err = 1'b0; rd = 32'h0;
    drive_a(m, 1'b1, we, addr, wd, c);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a_ram_we) wec++;
      d = (m == 0) ? a_m0.done : a_m1.done;
      if (d) begin
        lat = i;
        err = (m == 0) ? a_m0.err : a_m1.err;
        rd  = (m == 0) ? a_m0.rdata : a_m1.rdata;
        break;
      end
    end
    drive_a(m, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    checks++; if ({a_m0.done, a_m1.done, a_m0.err, a_m1.err} !== 4'b0) begin errors++; $display("FAIL reset_done_err: got %b want 0000", {a_m0.done, a_m1.done, a_m0.err, a_m1.err}); end
    checks++; if (a_ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", a_ram_we); end
    checks++; if (a_ram_addr !== 32'h0 || a_ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_ram_addr_wdata: got %h/%h want 0/0", a_ram_addr, a_ram_wdata); end
    checks++; if (a_ram_ctrl !== 3'b000) begin errors++; $display("FAIL reset_ram_ctrl: got %b want 000", a_ram_ctrl); end
    checks++; if (a_m0.rdata !== 32'h0 || a_m1.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", a_m0.rdata, a_m1.rdata); end
  endtask

  task automatic test_word();
    int lat, wec; logic err; logic [31:0] rd;
    run_a(0, 1'b1, 32'h10, 32'hDEADBEEF, RC_WORD, lat, wec, err, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL st_word_latency: got %0d want 2", lat); end
    checks++; if (wec !== 1) begin errors++; $display("FAIL st_word_we_cycles: got %0d want 1", wec); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL st_word_err: got %b want 0", err); end
    checks++; if (mem_a[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL st_word_mem: got %h want deadbeef", mem_a[4]); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL st_word_rdata_kept: got %h want 0", rd); end
    run_a(0, 1'b0, 32'h10, 32'h0, RC_WORD, lat, wec, err, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld_word_latency: got %0d want 2", lat); end
    checks++; if (wec !== 0) begin errors++; $display("FAIL ld_word_we_cycles: got %0d want 0", wec); end
    checks++; if (err !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_data: got err=%b %h want err=0 deadbeef", err, rd); end
  endtask

  task automatic test_byte_half();
    int lat, wec; logic err; logic [31:0] rd;
    run_a(1, 1'b1, 32'h13, 32'hAAAAAA80, RC_BYTE, lat, wec, err, rd);
    checks++; if (err !== 1'b0 || wec !== 1) begin errors++; $display("FAIL st_byte: got err=%b we=%0d want err=0 we=1", err, wec); end
    checks++; if (mem_a[4] !== 32'h80ADBEEF) begin errors++; $display("FAIL st_byte_mem: got %h want 80adbeef", mem_a[4]); end
    run_a(1, 1'b0, 32'h13, 32'h0, RC_BYTE, lat, wec, err, rd);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_signed: got %h want ffffff80", rd); end
    run_a(1, 1'b0, 32'h13, 32'h0, RC_BYTEU, lat, wec, err, rd);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL ld_byte_unsigned: got %h want 00000080", rd); end
    run_a(1, 1'b0, 32'h12, 32'h0, RC_HALF, lat, wec, err, rd);
    checks++; if (rd !== 32'hFFFF80AD || err !== 1'b0) begin errors++; $display("FAIL ld_half_signed: got err=%b %h want err=0 ffff80ad", err, rd); end
    run_a(1, 1'b0, 32'h12, 32'h0, RC_HALFU, lat, wec, err, rd);
    checks++; if (rd !== 32'h000080AD) begin errors++; $display("FAIL ld_half_unsigned: got %h want 000080ad", rd); end
  endtask

  task automatic test_errors();
    int lat, wec; logic err; logic [31:0] rd;
    run_a(0, 1'b1, 32'h21, 32'h0000FFFF, RC_HALF, lat, wec, err, rd);
    checks++; if (lat !== 2 || err !== 1'b1) begin errors++; $display("FAIL err_half_odd: got lat=%0d err=%b want lat=2 err=1", lat, err); end
    checks++; if (wec !== 0 || mem_a[8] !== 32'h0) begin errors++; $display("FAIL err_half_no_write: got we=%0d mem=%h want 0/0", wec, mem_a[8]); end
    run_a(0, 1'b1, 32'h400, 32'h55555555, 3'b000, lat, wec, err, rd);
    checks++; if (lat !== 2 || err !== 1'b1) begin errors++; $display("FAIL err_range: got lat=%0d err=%b want lat=2 err=1", lat, err); end
    checks++; if (wec !== 0 || mem_a[0] !== 32'h0) begin errors++; $display("FAIL err_range_no_write: got we=%0d mem=%h want 0/0", wec, mem_a[0]); end
    run_a(0, 1'b0, 32'h12, 32'h0, RC_WORD, lat, wec, err, rd);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_load_zero: got err=%b %h want err=1 0", err, rd); end
    run_a(0, 1'b0, 32'h13, 32'h0, RC_BYTEU, lat, wec, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h80) begin errors++; $display("FAIL byte_odd_ok: got err=%b %h want err=0 80", err, rd); end
  endtask

  task automatic test_back_to_back_rr();
    int lat, wec; logic err; logic [31:0] rd;
    int n; int t [4]; logic [3:0] order; logic both;
    run_a(1, 1'b0, 32'h10, 32'h0, RC_WORD, lat, wec, err, rd);   // m1 granted last
    n = 0; order = 4'b0; both = 1'b0;
    drive_a(0, 1'b1, 1'b0, 32'h10, 32'h0, RC_WORD);
    drive_a(1, 1'b1, 1'b0, 32'h13, 32'h0, RC_BYTEU);
    for (int i = 1; i <= 30 && n < 4; i++) begin
      tick();
      if (a_m0.done && a_m1.done) both = 1'b1;
      if (a_m0.done || a_m1.done) begin
        order[n] = a_m1.done;
        t[n] = i;
        n++;
      end
    end
    drive_a(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_a(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d want 4", n); end
    checks++; if (order !== 4'b1010) begin errors++; $display("FAIL rr_order: got %b want 1010 (bit0 first, 1=m1)", order); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_single_done: got %b want 0", both); end
    if (n == 4) begin
      checks++; if (t[0] !== 2 || t[1] !== 5 || t[2] !== 8 || t[3] !== 11) begin errors++; $display("FAIL rr_spacing: got %0d %0d %0d %0d want 2 5 8 11", t[0], t[1], t[2], t[3]); end
    end
    checks++; if (a_m0.rdata !== 32'h80ADBEEF || a_m1.rdata !== 32'h80) begin errors++; $display("FAIL rr_rdata: got %h/%h want 80adbeef/80", a_m0.rdata, a_m1.rdata); end
  endtask

  task automatic test_fixed_priority();
    int d0, d1, lat1;
    d0 = 0; d1 = 0; lat1 = -1;
    b_m0.req = 1'b1; b_m0.we = 1'b0; b_m0.addr = 32'h10; b_m0.wdata = 32'h0; b_m0.ctrl = RC_WORD;
    b_m1.req = 1'b1; b_m1.we = 1'b0; b_m1.addr = 32'h10; b_m1.wdata = 32'h0; b_m1.ctrl = RC_WORD;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (b_m0.done) d0++;
      if (b_m1.done) d1++;
    end
    b_m0.req = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (b_m1.done) begin lat1 = i; break; end
    end
    b_m1.req = 1'b0;
    tick();
    checks++; if (d0 !== 4 || d1 !== 0) begin errors++; $display("FAIL fixed_m0_wins: got m0=%0d m1=%0d want 4/0", d0, d1); end
    checks++; if (lat1 !== 2) begin errors++; $display("FAIL fixed_m1_after_drop: got %0d want 2", lat1); end
    checks++; if (b_m1.rdata !== 32'h11223344) begin errors++; $display("FAIL fixed_m1_rdata: got %h want 11223344", b_m1.rdata); end
  endtask

  task automatic test_reset_in_access();
    int lat, wec, nd; logic err; logic [31:0] rd;
    run_a(0, 1'b1, 32'h8, 32'hCAFEF00D, RC_WORD, lat, wec, err, rd);
    drive_a(0, 1'b1, 1'b1, 32'h8, 32'h12345678, RC_WORD);
    tick();
    checks++; if (a_ram_we !== 1'b1) begin errors++; $display("FAIL rst_access_we_before: got %b want 1", a_ram_we); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (a_ram_we !== 1'b0 || a_m0.done !== 1'b0) begin errors++; $display("FAIL rst_access_async: got we=%b done=%b want 0/0", a_ram_we, a_m0.done); end
    drive_a(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    checks++; if (mem_a[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_access_no_write: got %h want cafef00d", mem_a[2]); end
    #2 reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_m0.done || a_m1.done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rst_access_no_done: got %0d want 0", nd); end
    run_a(0, 1'b0, 32'h8, 32'h0, RC_WORD, lat, wec, err, rd);
    checks++; if (lat !== 2 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_access_reload: got lat=%0d %h want 2 cafef00d", lat, rd); end
  endtask

  task automatic test_drop_req();
    int lat, wec, nd; logic err; logic [31:0] rd;
    drive_a(1, 1'b1, 1'b0, 32'h10, 32'h0, RC_WORD);
    tick();
    drive_a(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (a_m1.done !== 1'b0) begin errors++; $display("FAIL drop_early_done: got %b want 0", a_m1.done); end
    tick();
    checks++; if (a_m1.done !== 1'b1 || a_m1.rdata !== 32'h80ADBEEF) begin errors++; $display("FAIL drop_done: got done=%b %h want 1 80adbeef", a_m1.done, a_m1.rdata); end
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_m0.done || a_m1.done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL drop_single_pulse: got %0d extra done want 0", nd); end
    run_a(1, 1'b0, 32'h13, 32'h0, RC_BYTE, lat, wec, err, rd);
    checks++; if (lat !== 2 || rd !== 32'hFFFFFF80) begin errors++; $display("FAIL drop_back_to_idle: got lat=%0d %h want 2 ffffff80", lat, rd); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_b[4] = 32'h11223344;
    drive_a(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_a(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    b_m0.req = 1'b0; b_m0.we = 1'b0; b_m0.addr = 32'h0; b_m0.wdata = 32'h0; b_m0.ctrl = 3'b000;
    b_m1.req = 1'b0; b_m1.we = 1'b0; b_m1.addr = 32'h0; b_m1.wdata = 32'h0; b_m1.ctrl = 3'b000;
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back_rr();
    test_fixed_priority();
    test_reset_in_access();
    test_drop_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
